// File: rtl/frame_dispatcher_pkg.sv
// -----------------------------------------------------------------------------
// frame_dispatcher_pkg
// Shared definitions for the SPI frame dispatcher: FSM state encoding,
// error-cause codes reported on err_kind, and the default sync marker.
// -----------------------------------------------------------------------------
package frame_dispatcher_pkg;

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_CHECK   = 2'd2
  } state_e;

  localparam logic ERR_CHECKSUM = 1'b0;
  localparam logic ERR_TIMEOUT  = 1'b1;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'h55;

endpackage : frame_dispatcher_pkg

// File: rtl/rdy_edge_sync.sv
// -----------------------------------------------------------------------------
// rdy_edge_sync
// Brings the SPI receiver's byte-ready flag into the clk domain through two
// flops and emits a single-cycle strobe for each rising edge of rdy. A rdy
// held high produces only one strobe.
//
// Ports:
//   clk    in   system clock
//   reset  in   asynchronous active-low reset
//   rdy    in   byte-ready, may be asynchronous to clk
//   strobe out  one-cycle pulse, high in the cycle after rdy is first sampled
// -----------------------------------------------------------------------------
module rdy_edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic rdy,
  output logic strobe
);

  logic rdy_latch_q;
  logic rdy_prev_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its source; blocking here would collapse the chain.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdy_latch_q <= 1'b0;
      rdy_prev_q  <= 1'b0;
    end else begin
      rdy_latch_q <= rdy;
      rdy_prev_q  <= rdy_latch_q;
    end
  end

  // Decoded from two flops only, so downstream logic sees a clean pulse.
  assign strobe = rdy_latch_q & ~rdy_prev_q;

endmodule : rdy_edge_sync

// File: rtl/frame_dispatcher.sv
// -----------------------------------------------------------------------------
// frame_dispatcher
// Hunts for SYNC_BYTE in the SPI byte stream, collects NUM_CH payload bytes
// (plus an optional 8-bit additive checksum) into a shadow array, and commits
// all channels to ch_out on a single edge. Frames stalled longer than
// TIMEOUT_CYC clocks between bytes, or with a bad checksum, are discarded and
// reported on frame_err/err_kind.
//
// Ports:
//   clk          in   system clock
//   reset        in   asynchronous active-low reset
//   buff_rx_spi  in   received byte, stable from rdy rise until consumed
//   rdy          in   byte-ready from SPI receiver (asynchronous)
//   ch_out       out  channel registers, channel i = [8i+7:8i]
//   frame_valid  out  one-cycle pulse on the edge ch_out updates
//   frame_err    out  one-cycle pulse when a frame is discarded
//   err_kind     out  cause of last error (0 checksum, 1 timeout)
//   busy         out  high while inside a frame (PAYLOAD or CHECK)
// -----------------------------------------------------------------------------
module frame_dispatcher
  import frame_dispatcher_pkg::*;
#(
  parameter int unsigned NUM_CH      = 7,
  parameter logic [7:0]  SYNC_BYTE   = DEFAULT_SYNC_BYTE,
  parameter bit          CHK_EN      = 1'b1,
  parameter int unsigned TIMEOUT_CYC = 65535
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [7:0]          buff_rx_spi,
  input  logic                rdy,
  output logic [8*NUM_CH-1:0] ch_out,
  output logic                frame_valid,
  output logic                frame_err,
  output logic                err_kind,
  output logic                busy
);

  localparam int unsigned IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned TMO_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam bit          TMO_EN = (TIMEOUT_CYC != 0);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);
  // The counter value seen on the edge that would make it reach TIMEOUT_CYC;
  // firing there puts frame_err exactly TIMEOUT_CYC clocks after the strobe.
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  logic strobe;

  state_e                state_q;
  logic [IDX_W-1:0]      idx_q;
  logic [7:0]            sum_q;
  logic [TMO_W-1:0]      tmo_cnt_q;
  logic [7:0]            shadow_q [NUM_CH];
  logic [8*NUM_CH-1:0]   ch_out_q;
  logic                  frame_valid_q;
  logic                  frame_err_q;
  logic                  err_kind_q;
  logic                  busy_q;

  logic [7:0]            sum_d;
  logic [8*NUM_CH-1:0]   commit_vec_d;
  logic                  tmo_hit;

  rdy_edge_sync u_rdy_edge_sync (
    .clk    (clk),
    .reset  (reset),
    .rdy    (rdy),
    .strobe (strobe)
  );

  assign sum_d = sum_q + buff_rx_spi;

  // Value ch_out takes on commit. Without a checksum the commit happens on the
  // edge that consumes the last payload byte, so that byte bypasses the shadow.
  // NOTE: every combinational output gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    commit_vec_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      commit_vec_d[8*i +: 8] = shadow_q[i];
    end
    if (!CHK_EN) begin
      commit_vec_d[8*(NUM_CH-1) +: 8] = buff_rx_spi;
    end
  end

  // A strobe on the same edge always wins over the timeout.
  assign tmo_hit = TMO_EN && !strobe && (state_q != ST_HUNT) && (tmo_cnt_q == TMO_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_HUNT;
      idx_q         <= '0;
      sum_q         <= 8'h00;
      tmo_cnt_q     <= '0;
      ch_out_q      <= '0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      err_kind_q    <= 1'b0;
      busy_q        <= 1'b0;
      // NOTE: the shadow array is only NUM_CH flops wide and has a defined
      // reset value, so it is reset like any other register rather than
      // being left as an uninitialised RAM.
      for (int i = 0; i < NUM_CH; i++) begin
        shadow_q[i] <= 8'h00;
      end
    end else begin
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;

      if (!TMO_EN || state_q == ST_HUNT || strobe || tmo_hit) begin
        tmo_cnt_q <= '0;
      end else begin
        tmo_cnt_q <= tmo_cnt_q + 1'b1;
      end

      unique case (state_q)
        ST_HUNT: begin
          if (strobe && buff_rx_spi == SYNC_BYTE) begin
            idx_q   <= '0;
            sum_q   <= 8'h00;
            state_q <= ST_PAYLOAD;
            busy_q  <= 1'b1;
          end
        end

        ST_PAYLOAD: begin
          if (strobe) begin
            // Sync-valued bytes land here as ordinary data.
            shadow_q[idx_q] <= buff_rx_spi;
            sum_q           <= sum_d;
            idx_q           <= idx_q + 1'b1;
            if (idx_q == LAST_IDX) begin
              if (CHK_EN) begin
                state_q <= ST_CHECK;
              end else begin
                ch_out_q      <= commit_vec_d;
                frame_valid_q <= 1'b1;
                idx_q         <= '0;
                state_q       <= ST_HUNT;
                busy_q        <= 1'b0;
              end
            end
          end else if (tmo_hit) begin
            frame_err_q <= 1'b1;
            err_kind_q  <= ERR_TIMEOUT;
            idx_q       <= '0;
            state_q     <= ST_HUNT;
            busy_q      <= 1'b0;
          end
        end

        ST_CHECK: begin
          if (strobe) begin
            if (buff_rx_spi == sum_q) begin
              ch_out_q      <= commit_vec_d;
              frame_valid_q <= 1'b1;
            end else begin
              frame_err_q <= 1'b1;
              err_kind_q  <= ERR_CHECKSUM;
            end
            idx_q   <= '0;
            state_q <= ST_HUNT;
            busy_q  <= 1'b0;
          end else if (tmo_hit) begin
            frame_err_q <= 1'b1;
            err_kind_q  <= ERR_TIMEOUT;
            idx_q       <= '0;
            state_q     <= ST_HUNT;
            busy_q      <= 1'b0;
          end
        end

        default: begin
          state_q <= ST_HUNT;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ch_out      = ch_out_q;
  assign frame_valid = frame_valid_q;
  assign frame_err   = frame_err_q;
  assign err_kind    = err_kind_q;
  assign busy        = busy_q;

endmodule : frame_dispatcher

// File: tb/tb_frame_dispatcher.sv
// -----------------------------------------------------------------------------
// tb_frame_dispatcher
// Directed bench for frame_dispatcher. dut_a: NUM_CH=7, checksum on,
// TIMEOUT_CYC=100. dut_b: NUM_CH=3, checksum off. Both share clk and reset.
// -----------------------------------------------------------------------------
module tb_frame_dispatcher;

  logic        clk   = 1'b0;
  logic        reset = 1'b0;

  logic [7:0]  byte_a = 8'h00;
  logic        rdy_a  = 1'b0;
  logic [55:0] ch_a;
  logic        fv_a, fe_a, ek_a, busy_a;

  logic [7:0]  byte_b = 8'h00;
  logic        rdy_b  = 1'b0;
  logic [23:0] ch_b;
  logic        fv_b, fe_b, ek_b, busy_b;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int fv_cnt_a  = 0;
  int fe_cnt_a  = 0;
  int fv_cnt_b  = 0;

  always #5 clk = ~clk;

  frame_dispatcher #(
    .NUM_CH      (7),
    .SYNC_BYTE   (8'h55),
    .CHK_EN      (1'b1),
    .TIMEOUT_CYC (100)
  ) dut_a (
    .clk         (clk),
    .reset       (reset),
    .buff_rx_spi (byte_a),
    .rdy         (rdy_a),
    .ch_out      (ch_a),
    .frame_valid (fv_a),
    .frame_err   (fe_a),
    .err_kind    (ek_a),
    .busy        (busy_a)
  );

  frame_dispatcher #(
    .NUM_CH      (3),
    .SYNC_BYTE   (8'h55),
    .CHK_EN      (1'b0),
    .TIMEOUT_CYC (100)
  ) dut_b (
    .clk         (clk),
    .reset       (reset),
    .buff_rx_spi (byte_b),
    .rdy         (rdy_b),
    .ch_out      (ch_b),
    .frame_valid (fv_b),
    .frame_err   (fe_b),
    .err_kind    (ek_b),
    .busy        (busy_b)
  );

  // Pulse counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (fv_a) fv_cnt_a++;
    if (fe_a) fe_cnt_a++;
    if (fv_b) fv_cnt_b++;
  end

  // Raise rdy at a falling edge; returns 1ns after the consuming edge (k+1).
  task automatic drive_byte(input bit to_b, input logic [7:0] b);
    @(negedge clk);
    if (to_b) begin
      byte_b = b;
      rdy_b  = 1'b1;
    end else begin
      byte_a = b;
      rdy_a  = 1'b1;
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    rdy_a = 1'b0;
    rdy_b = 1'b0;
  endtask

  // Full byte including the two low cycles required before the next one.
  task automatic send_byte(input bit to_b, input logic [7:0] b);
    drive_byte(to_b, b);
    repeat (2) @(posedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    total_cnt++; if (ch_a !== 56'h0) $display("FAIL reset_ch_a: got %h expected %h", ch_a, 56'h0); else pass_cnt++;
    total_cnt++; if (fv_a !== 1'b0) $display("FAIL reset_fv_a: got %b expected 0", fv_a); else pass_cnt++;
    total_cnt++; if (fe_a !== 1'b0) $display("FAIL reset_fe_a: got %b expected 0", fe_a); else pass_cnt++;
    total_cnt++; if (ek_a !== 1'b0) $display("FAIL reset_ek_a: got %b expected 0", ek_a); else pass_cnt++;
    total_cnt++; if (busy_a !== 1'b0) $display("FAIL reset_busy_a: got %b expected 0", busy_a); else pass_cnt++;
    total_cnt++; if (ch_b !== 24'h0) $display("FAIL reset_ch_b: got %h expected %h", ch_b, 24'h0); else pass_cnt++;
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++; if (busy_b !== 1'b0) $display("FAIL post_reset_busy_b: got %b expected 0", busy_b); else pass_cnt++;
  endtask

  task automatic test_nominal();
    int fv0, fe0;
    logic [7:0] bytes [8];
    bytes = '{8'h55, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
    fv0 = fv_cnt_a;
    fe0 = fe_cnt_a;
    for (int i = 0; i < 8; i++) send_byte(1'b0, bytes[i]);
    total_cnt++; if (busy_a !== 1'b1) $display("FAIL nominal_busy: got %b expected 1", busy_a); else pass_cnt++;
    drive_byte(1'b0, 8'h1C);
    total_cnt++; if (fv_a !== 1'b1) $display("FAIL nominal_fv: got %b expected 1", fv_a); else pass_cnt++;
    total_cnt++; if (ch_a !== 56'h07060504030201) $display("FAIL nominal_ch: got %h expected %h", ch_a, 56'h07060504030201); else pass_cnt++;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++; if (fv_cnt_a - fv0 !== 1) $display("FAIL nominal_fv_count: got %0d expected 1", fv_cnt_a - fv0); else pass_cnt++;
    total_cnt++; if (fe_cnt_a - fe0 !== 0) $display("FAIL nominal_err_count: got %0d expected 0", fe_cnt_a - fe0); else pass_cnt++;
  endtask

  task automatic test_bad_checksum();
    int fv0;
    logic [7:0] bytes [8];
    bytes = '{8'h55, 8'hAA, 8'hBB, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    fv0 = fv_cnt_a;
    for (int i = 0; i < 8; i++) send_byte(1'b0, bytes[i]);
    // Payload sums to 0x65, so a checksum of 00 is wrong.
    drive_byte(1'b0, 8'h00);
    total_cnt++; if (fe_a !== 1'b1) $display("FAIL badchk_fe: got %b expected 1", fe_a); else pass_cnt++;
    total_cnt++; if (ek_a !== 1'b0) $display("FAIL badchk_kind: got %b expected 0", ek_a); else pass_cnt++;
    total_cnt++; if (ch_a !== 56'h07060504030201) $display("FAIL badchk_ch_held: got %h expected %h", ch_a, 56'h07060504030201); else pass_cnt++;
    total_cnt++; if (busy_a !== 1'b0) $display("FAIL badchk_busy: got %b expected 0", busy_a); else pass_cnt++;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++; if (fv_cnt_a - fv0 !== 0) $display("FAIL badchk_fv_count: got %0d expected 0", fv_cnt_a - fv0); else pass_cnt++;
  endtask

  task automatic test_hunt_sync();
    logic [7:0] bytes [8];
    bytes = '{8'h55, 8'h55, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01};
    send_byte(1'b0, 8'h12);
    send_byte(1'b0, 8'h34);
    total_cnt++; if (busy_a !== 1'b0) $display("FAIL hunt_ignore_busy: got %b expected 0", busy_a); else pass_cnt++;
    for (int i = 0; i < 8; i++) send_byte(1'b0, bytes[i]);
    // Payload 55 01 01 01 01 01 01 sums to 0x5B.
    drive_byte(1'b0, 8'h5B);
    total_cnt++; if (fv_a !== 1'b1) $display("FAIL hunt_fv: got %b expected 1", fv_a); else pass_cnt++;
    total_cnt++; if (ch_a !== 56'h01010101010155) $display("FAIL hunt_ch: got %h expected %h", ch_a, 56'h01010101010155); else pass_cnt++;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_timeout();
    bit early;
    logic [7:0] bytes [8];
    bytes = '{8'h55, 8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70};
    early = 1'b0;
    send_byte(1'b0, 8'h55);
    send_byte(1'b0, 8'h01);
    drive_byte(1'b0, 8'h02);
    // Now 1ns after the last strobe's edge; the error belongs on edge +100.
    for (int i = 1; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (fe_a) early = 1'b1;
    end
    total_cnt++; if (early !== 1'b0) $display("FAIL timeout_early: got %b expected 0", early); else pass_cnt++;
    total_cnt++; if (busy_a !== 1'b1) $display("FAIL timeout_busy_before: got %b expected 1", busy_a); else pass_cnt++;
    @(posedge clk);
    #1;
    total_cnt++; if (fe_a !== 1'b1) $display("FAIL timeout_fe: got %b expected 1", fe_a); else pass_cnt++;
    total_cnt++; if (ek_a !== 1'b1) $display("FAIL timeout_kind: got %b expected 1", ek_a); else pass_cnt++;
    total_cnt++; if (busy_a !== 1'b0) $display("FAIL timeout_busy_after: got %b expected 0", busy_a); else pass_cnt++;
    total_cnt++; if (ch_a !== 56'h01010101010155) $display("FAIL timeout_ch_held: got %h expected %h", ch_a, 56'h01010101010155); else pass_cnt++;
    for (int i = 0; i < 8; i++) send_byte(1'b0, bytes[i]);
    drive_byte(1'b0, 8'hC0);
    total_cnt++; if (fv_a !== 1'b1) $display("FAIL timeout_next_fv: got %b expected 1", fv_a); else pass_cnt++;
    total_cnt++; if (ch_a !== 56'h70605040302010) $display("FAIL timeout_next_ch: got %h expected %h", ch_a, 56'h70605040302010); else pass_cnt++;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_reset_mid_frame();
    int fv0;
    logic [7:0] bytes [8];
    bytes = '{8'h55, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
    send_byte(1'b0, 8'h55);
    send_byte(1'b0, 8'h11);
    send_byte(1'b0, 8'h22);
    send_byte(1'b0, 8'h33);
    #1;
    total_cnt++; if (busy_a !== 1'b1) $display("FAIL midrst_busy_before: got %b expected 1", busy_a); else pass_cnt++;
    #2;
    reset = 1'b0;
    #1;
    total_cnt++; if (ch_a !== 56'h0) $display("FAIL midrst_ch: got %h expected %h", ch_a, 56'h0); else pass_cnt++;
    total_cnt++; if (busy_a !== 1'b0) $display("FAIL midrst_busy: got %b expected 0", busy_a); else pass_cnt++;
    total_cnt++; if (fv_a !== 1'b0) $display("FAIL midrst_fv: got %b expected 0", fv_a); else pass_cnt++;
    @(negedge clk);
    reset = 1'b1;
    fv0 = fv_cnt_a;
    drive_byte(1'b0, 8'h44);
    total_cnt++; if (busy_a !== 1'b0) $display("FAIL midrst_hunting: got %b expected 0", busy_a); else pass_cnt++;
    repeat (2) @(posedge clk);
    for (int i = 0; i < 8; i++) send_byte(1'b0, bytes[i]);
    total_cnt++; if (fv_cnt_a - fv0 !== 0) $display("FAIL midrst_no_commit: got %0d expected 0", fv_cnt_a - fv0); else pass_cnt++;
    drive_byte(1'b0, 8'h1C);
    total_cnt++; if (ch_a !== 56'h07060504030201) $display("FAIL midrst_next_ch: got %h expected %h", ch_a, 56'h07060504030201); else pass_cnt++;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_no_checksum();
    send_byte(1'b1, 8'h55);
    send_byte(1'b1, 8'hA0);
    send_byte(1'b1, 8'hB1);
    @(negedge clk);
    byte_b = 8'hC2;
    rdy_b  = 1'b1;
    @(posedge clk);  // edge k: rdy first sampled
    #1;
    total_cnt++; if (fv_b !== 1'b0) $display("FAIL nochk_fv_at_k: got %b expected 0", fv_b); else pass_cnt++;
    @(posedge clk);  // edge k+1: C2 consumed and committed
    #1;
    total_cnt++; if (fv_b !== 1'b1) $display("FAIL nochk_fv_at_k1: got %b expected 1", fv_b); else pass_cnt++;
    total_cnt++; if (ch_b !== 24'hC2B1A0) $display("FAIL nochk_ch: got %h expected %h", ch_b, 24'hC2B1A0); else pass_cnt++;
    total_cnt++; if (busy_b !== 1'b0) $display("FAIL nochk_busy: got %b expected 0", busy_b); else pass_cnt++;
    rdy_b = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_rdy_held();
    int fv0;
    fv0 = fv_cnt_b;
    // A held sync byte must start exactly one frame; repeated strobes would
    // fill all three channels with 55 and commit.
    @(negedge clk);
    byte_b = 8'h55;
    rdy_b  = 1'b1;
    repeat (50) @(posedge clk);
    #1;
    total_cnt++; if (busy_b !== 1'b1) $display("FAIL held_busy: got %b expected 1", busy_b); else pass_cnt++;
    total_cnt++; if (fv_cnt_b - fv0 !== 0) $display("FAIL held_fv_count: got %0d expected 0", fv_cnt_b - fv0); else pass_cnt++;
    total_cnt++; if (ch_b !== 24'hC2B1A0) $display("FAIL held_ch: got %h expected %h", ch_b, 24'hC2B1A0); else pass_cnt++;
    rdy_b = 1'b0;
    repeat (2) @(posedge clk);
    send_byte(1'b1, 8'h01);
    send_byte(1'b1, 8'h02);
    drive_byte(1'b1, 8'h03);
    total_cnt++; if (ch_b !== 24'h030201) $display("FAIL held_next_ch: got %h expected %h", ch_b, 24'h030201); else pass_cnt++;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_bad_checksum();
    test_hunt_sync();
    test_timeout();
    test_reset_mid_frame();
    test_no_checksum();
    test_rdy_held();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule : tb_frame_dispatcher
